// File: rtl/cpu_step_ctrl.sv
// Run/step controller: turns the divider's slow tick level into one-cycle CPU enable pulses, gated by run/pause and single-step buttons.
// Latency: tick_in sampled high at edge E -> cpu_en high for the cycle after edge E+1; raw button press -> press event after 2 + DEBOUNCE_N cycles.
// Backpressure: none; the CPU consumes every cpu_en pulse, and at most one pulse is issued per tick_in rising edge.
//
// Ports:
//   clk, rst     - system clock; asynchronous active-high reset
//   tick_in      - clock-divider square wave, already in the clk domain
//   btn_mode     - raw asynchronous button, a press toggles run/pause
//   btn_step     - raw asynchronous button, a press requests a single step
//   cpu_en       - registered one-cycle enable pulse to the CPU
//   running      - registered, high while the FSM is in RUNNING
//   step_count   - cpu_en pulses issued since reset, wraps silently

module cpu_step_ctrl #(
    parameter int DEBOUNCE_N = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_in,
    input  logic        btn_mode,
    input  logic        btn_step,
    output logic        cpu_en,
    output logic        running,
    output logic [31:0] step_count
);

    // Counter only ever needs to reach DEBOUNCE_N-1 before the debounced level flips.
    localparam int            CW       = (DEBOUNCE_N < 1) ? 1 : $clog2(DEBOUNCE_N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_N - 1);

    localparam int BTN_MODE = 0;
    localparam int BTN_STEP = 1;

    typedef enum logic [1:0] {
        PAUSED    = 2'd0,
        RUNNING   = 2'd1,
        STEP_WAIT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Tick edge detect
    // ------------------------------------------------------------------
    // tick_s_q samples tick_in; tick_q holds the previous sample. Both
    // reset high so a tick_in already high at reset release is not an edge.
    // The sampling stage puts tick_rise in the cycle after the sampling edge,
    // which gives the E -> E+1 pulse timing.
    logic tick_s_q, tick_s_d;
    logic tick_q,   tick_d;
    logic tick_rise;

    always_comb begin
        tick_s_d = tick_in;
        tick_d   = tick_s_q;
    end

    assign tick_rise = tick_s_q & ~tick_q;

    // ------------------------------------------------------------------
    // Button synchronise + debounce, bit 0 = mode, bit 1 = step
    // ------------------------------------------------------------------
    logic [1:0]    btn_raw;
    logic [1:0]    sync1_q, sync1_d;
    logic [1:0]    sync2_q, sync2_d;
    logic [1:0]    db_q,    db_d;
    logic [1:0]    ev_q,    ev_d;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic          mode_ev;
    logic          step_ev;

    assign btn_raw = {btn_step, btn_mode};

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        db_d    = db_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            // Any return to the debounced level clears the count, so a
            // bounce shorter than DEBOUNCE_N cycles never flips the level.
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        // Press events only; releases are silent.
        ev_d = db_d & ~db_q;
    end

    assign mode_ev = ev_q[BTN_MODE];
    assign step_ev = ev_q[BTN_STEP];

    // ------------------------------------------------------------------
    // Run/step FSM
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic        cpu_en_q, cpu_en_d;
    logic        running_q, running_d;
    logic [31:0] step_count_q, step_count_d;

    always_comb begin
        state_d  = state_q;
        cpu_en_d = 1'b0;
        unique case (state_q)
            PAUSED: begin
                // Mode beats step when both presses land together.
                if (mode_ev) begin
                    state_d = RUNNING;
                end else if (step_ev) begin
                    state_d = STEP_WAIT;
                end
            end
            RUNNING: begin
                if (tick_rise) begin
                    cpu_en_d = 1'b1;
                end
                if (mode_ev) begin
                    state_d = PAUSED;
                end
            end
            STEP_WAIT: begin
                // A tick coinciding with a mode press still delivers the step.
                if (tick_rise) begin
                    cpu_en_d = 1'b1;
                    state_d  = PAUSED;
                end else if (mode_ev) begin
                    state_d = PAUSED;
                end
            end
            default: begin
                state_d = PAUSED;
            end
        endcase
        // Registered copy of the state decode so running tracks state_q exactly.
        running_d    = (state_d == RUNNING);
        step_count_d = step_count_q + {31'd0, cpu_en_d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_s_q     <= 1'b1;
            tick_q       <= 1'b1;
            sync1_q      <= '0;
            sync2_q      <= '0;
            db_q         <= '0;
            ev_q         <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
            state_q      <= PAUSED;
            cpu_en_q     <= 1'b0;
            running_q    <= 1'b0;
            step_count_q <= '0;
        end else begin
            tick_s_q     <= tick_s_d;
            tick_q       <= tick_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            db_q         <= db_d;
            ev_q         <= ev_d;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            state_q      <= state_d;
            cpu_en_q     <= cpu_en_d;
            running_q    <= running_d;
            step_count_q <= step_count_d;
        end
    end

    assign cpu_en     = cpu_en_q;
    assign running    = running_q;
    assign step_count = step_count_q;

endmodule
